// File: rtl/bcd_updown_counter.sv
// ============================================================================
// Module   : bcd_updown_counter
// Brief    : Debounced push-button up/down modulo counter with 7-segment output
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_updown_counter #(
  parameter int MODULUS    = 12,
  parameter int DIGITS     = 2,
  parameter int DEB_CYCLES = 4,
  parameter int BLANK_LZ   = 1
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET_N,
  input  logic                         V_BT,
  input  logic                         SW_DIR,
  input  logic                         SW_EN,
  output logic [$clog2(MODULUS)-1:0]   COUNT,
  output logic                         WRAP,
  output logic [7*DIGITS-1:0]          HEX
);

  localparam int CW  = $clog2(MODULUS);
  localparam int DBW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]  MAX_COUNT = CW'(MODULUS - 1);
  localparam logic [DBW-1:0] DEB_LAST  = DBW'(DEB_CYCLES - 1);

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic [DBW-1:0]  cnt_q, cnt_d;
  logic            deb_level_q, deb_level_d;
  logic            deb_dly_q, deb_dly_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wrap_q, wrap_d;
  logic            step;

  always_comb begin
    s1_d        = V_BT;
    s2_d        = s1_q;
    deb_dly_d   = deb_level_q;
    cnt_d       = '0;
    deb_level_d = deb_level_q;
    count_d     = count_q;
    wrap_d      = 1'b0;
    step        = deb_level_q & ~deb_dly_q;

    // A new level is accepted only after DEB_CYCLES consecutive mismatches.
    if (s2_q != deb_level_q) begin
      if (cnt_q == DEB_LAST) begin
        deb_level_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (step && SW_EN) begin
      if (SW_DIR) begin
        if (count_q == MAX_COUNT) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_COUNT;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      cnt_q       <= '0;
      deb_level_q <= 1'b0;
      deb_dly_q   <= 1'b0;
      count_q     <= '0;
      wrap_q      <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      cnt_q       <= cnt_d;
      deb_level_q <= deb_level_d;
      deb_dly_q   <= deb_dly_d;
      count_q     <= count_d;
      wrap_q      <= wrap_d;
    end
  end

  assign COUNT = count_q;
  assign WRAP  = wrap_q;

  logic [31:0] count_ext;
  assign count_ext = 32'(count_q);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam int unsigned POW = 10 ** i;
    logic [3:0] digit;
    logic       blank;
    logic [6:0] seg;

    always_comb begin
      digit = 4'((count_ext / POW) % 32'd10);
      blank = (BLANK_LZ != 0) && (i > 0) && (count_ext < POW);
      seg   = 7'b1111111;
      if (!blank) begin
        case (digit)
          4'd0:    seg = 7'b0000001;
          4'd1:    seg = 7'b1001111;
          4'd2:    seg = 7'b0010010;
          4'd3:    seg = 7'b0000110;
          4'd4:    seg = 7'b1001100;
          4'd5:    seg = 7'b0100100;
          4'd6:    seg = 7'b0100000;
          4'd7:    seg = 7'b0001111;
          4'd8:    seg = 7'b0000000;
          4'd9:    seg = 7'b0000100;
          default: seg = 7'b1111111;
        endcase
      end
    end

    assign HEX[7*i +: 7] = seg;
  end

endmodule

`default_nettype wire
